// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register map, CTRL bit
// positions and the run-state encoding.
package timer_pkg;

   localparam logic [4:0] OFF_CTRL     = 5'h00;
   localparam logic [4:0] OFF_LOAD     = 5'h04;
   localparam logic [4:0] OFF_COUNT    = 5'h08;
   localparam logic [4:0] OFF_PRESCALE = 5'h0C;
   localparam logic [4:0] OFF_STATUS   = 5'h10;

   localparam int CTRL_W    = 3;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 2;
   localparam int STAT_PEND = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } timer_state_t;

   // Registers are word aligned, so only the word index selects a register.
   function automatic logic [2:0] word_idx(input logic [4:0] byte_off);
      return byte_off[4:2];
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: ticks when the count reaches the programmed limit
// and then restarts from zero; held at zero while disabled or cleared.
module timer_prescaler #(
   parameter int PSC_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [PSC_W-1:0] prescale_i,
   output logic             tick_o
);

   logic [PSC_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && !clr_i && (cnt_q == prescale_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PSC_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timer_mmio.sv
// Memory-mapped up-counting timer with prescaler, one-shot or auto-reload
// operation and a level interrupt cleared by W1C or the controller's finish pulse.
module timer_mmio
   import timer_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PSC_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o,
   input  logic        int_fin_i
);

   timer_state_t      state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  load_q, load_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PSC_W-1:0]  prescale_q, prescale_d;
   logic              pend_q, pend_d;
   logic [31:0]       rdata_q, rdata_d;

   logic        run;
   logic        tick;
   logic        wr, rd;
   logic        wr_ctrl, wr_load, wr_count, wr_prescale, wr_status;
   logic        expire;
   logic [31:0] rd_val;
   logic        unused_addr;

   assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

   assign run = (state_q == ST_RUN);

   timer_prescaler #(
      .PSC_W(PSC_W)
   ) u_prescaler (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .en_i      (run),
      .clr_i     (!run),
      .prescale_i(prescale_q),
      .tick_o    (tick)
   );

   assign wr          = req_i && we_i;
   assign rd          = req_i && !we_i;
   assign wr_ctrl     = wr && (addr_i[4:2] == word_idx(OFF_CTRL));
   assign wr_load     = wr && (addr_i[4:2] == word_idx(OFF_LOAD));
   assign wr_count    = wr && (addr_i[4:2] == word_idx(OFF_COUNT));
   assign wr_prescale = wr && (addr_i[4:2] == word_idx(OFF_PRESCALE));
   assign wr_status   = wr && (addr_i[4:2] == word_idx(OFF_STATUS));

   // A software COUNT write in the same cycle suppresses both increment and expiry.
   assign expire = run && tick && !wr_count && (count_q == load_q);

   always_comb begin
      rd_val = '0;
      case (addr_i[4:2])
         word_idx(OFF_CTRL):     rd_val = 32'(ctrl_q);
         word_idx(OFF_LOAD):     rd_val = 32'(load_q);
         word_idx(OFF_COUNT):    rd_val = 32'(count_q);
         word_idx(OFF_PRESCALE): rd_val = 32'(prescale_q);
         word_idx(OFF_STATUS):   rd_val = 32'(pend_q);
         default:                rd_val = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      count_d    = count_q;
      prescale_d = prescale_q;
      pend_d     = pend_q;
      rdata_d    = rdata_q;

      if (wr_ctrl)     ctrl_d     = wdata_i[CTRL_W-1:0];
      if (wr_load)     load_d     = wdata_i[CNT_W-1:0];
      if (wr_prescale) prescale_d = wdata_i[PSC_W-1:0];
      if (rd)          rdata_d    = rd_val;

      case (state_q)
         ST_IDLE: begin
            if (wr_ctrl && wdata_i[CTRL_EN]) state_d = ST_RUN;
         end
         ST_RUN: begin
            // A one-shot expiry wins over a concurrent CTRL write: EN is forced low.
            if (expire && !ctrl_q[CTRL_AUTO]) begin
               state_d        = ST_DONE;
               ctrl_d[CTRL_EN] = 1'b0;
            end else if (wr_ctrl && !wdata_i[CTRL_EN]) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (wr_ctrl && wdata_i[CTRL_EN]) begin
               state_d = ST_RUN;
               count_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (expire) begin
         count_d = ctrl_q[CTRL_AUTO] ? '0 : load_q;
      end else if (run && tick) begin
         count_d = count_q + CNT_W'(1);
      end
      if (wr_count) count_d = wdata_i[CNT_W-1:0];

      // Set beats clear so an expiry coinciding with an acknowledge is not lost.
      if (int_fin_i || (wr_status && wdata_i[STAT_PEND])) pend_d = 1'b0;
      if (expire) pend_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= '0;
         load_q     <= '0;
         count_q    <= '0;
         prescale_q <= '0;
         pend_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         load_q     <= load_d;
         count_q    <= count_d;
         prescale_q <= prescale_d;
         pend_q     <= pend_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;
   assign irq_o   = pend_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_timer_mmio.sv
// Directed self-checking bench for timer_mmio: bus ops are issued from a
// falling edge so each one lands on the following rising edge.
module tb_timer_mmio;
   import timer_pkg::*;

   localparam logic [31:0] A_CTRL     = 32'h00;
   localparam logic [31:0] A_LOAD     = 32'h04;
   localparam logic [31:0] A_COUNT    = 32'h08;
   localparam logic [31:0] A_PRESCALE = 32'h0C;
   localparam logic [31:0] A_STATUS   = 32'h10;
   localparam logic [31:0] A_HOLE     = 32'h14;

   logic        clk_i;
   logic        rst_n_i;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        irq_o;
   logic        int_fin_i;

   int total;
   int bad;

   timer_mmio #(
      .CNT_W(32),
      .PSC_W(16)
   ) u_dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .req_i    (req_i),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata_o),
      .irq_o    (irq_o),
      .int_fin_i(int_fin_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Called at a falling edge; the access happens on the next rising edge and
   // the task returns at the falling edge after it.
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] data);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = addr;
      wdata_i = data;
      @(negedge clk_i);
      req_i   = 1'b0;
      we_i    = 1'b0;
      wdata_i = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic readCheck(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
      applyStimulus(1'b0, addr, 32'h0);
      checkOutput(tag, rdata_o, expected);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n_i   = 1'b0;
      req_i     = 1'b0;
      we_i      = 1'b0;
      addr_i    = '0;
      wdata_i   = '0;
      int_fin_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      $display("[TB] reset values");
      checkOutput("rst_irq", 32'(irq_o), 32'd0);
      readCheck("rst_ctrl", A_CTRL, 32'd0);
      readCheck("rst_load", A_LOAD, 32'd0);
      readCheck("rst_count", A_COUNT, 32'd0);
      readCheck("rst_prescale", A_PRESCALE, 32'd0);
      readCheck("rst_status", A_STATUS, 32'd0);

      $display("[TB] register map, hole, truncation");
      applyStimulus(1'b1, A_LOAD, 32'h0000_05A5);
      readCheck("load_rw", A_LOAD, 32'h0000_05A5);
      applyStimulus(1'b1, A_HOLE, 32'hFFFF_FFFF);
      readCheck("hole_read", A_HOLE, 32'd0);
      applyStimulus(1'b1, A_PRESCALE, 32'hFFFF_1234);
      readCheck("psc_trunc", A_PRESCALE, 32'h0000_1234);

      $display("[TB] one-shot expiry on fourth tick");
      applyStimulus(1'b1, A_PRESCALE, 32'd0);
      applyStimulus(1'b1, A_LOAD, 32'd3);
      applyStimulus(1'b1, A_CTRL, 32'b101);
      repeat (3) @(negedge clk_i);
      checkOutput("os_irq_before", 32'(irq_o), 32'd0);
      @(negedge clk_i);
      checkOutput("os_irq_at", 32'(irq_o), 32'd1);
      checkOutput("os_state", 32'(u_dut.state_q), 32'(ST_DONE));
      readCheck("os_count", A_COUNT, 32'd3);
      readCheck("os_ctrl", A_CTRL, 32'b100);
      readCheck("os_status", A_STATUS, 32'd1);
      applyStimulus(1'b1, A_STATUS, 32'd1);
      checkOutput("w1c_irq", 32'(irq_o), 32'd0);

      $display("[TB] auto-reload with prescaler");
      applyStimulus(1'b1, A_PRESCALE, 32'd4);
      applyStimulus(1'b1, A_LOAD, 32'd2);
      applyStimulus(1'b1, A_CTRL, 32'b111);
      readCheck("ar_count0", A_COUNT, 32'd0);
      repeat (4) @(negedge clk_i);
      readCheck("ar_count1", A_COUNT, 32'd1);
      repeat (4) @(negedge clk_i);
      readCheck("ar_count2", A_COUNT, 32'd2);
      repeat (3) @(negedge clk_i);
      checkOutput("ar_irq_pre1", 32'(irq_o), 32'd0);
      @(negedge clk_i);
      checkOutput("ar_irq_rise1", 32'(irq_o), 32'd1);
      readCheck("ar_count_wrap", A_COUNT, 32'd0);
      applyStimulus(1'b1, A_STATUS, 32'd1);
      checkOutput("ar_irq_clr", 32'(irq_o), 32'd0);
      repeat (12) @(negedge clk_i);
      checkOutput("ar_irq_pre2", 32'(irq_o), 32'd0);
      @(negedge clk_i);
      checkOutput("ar_irq_rise2", 32'(irq_o), 32'd1);

      $display("[TB] expiry versus int_fin");
      repeat (14) @(negedge clk_i);
      int_fin_i = 1'b1;
      @(negedge clk_i);
      int_fin_i = 1'b0;
      checkOutput("fin_vs_expiry", 32'(irq_o), 32'd1);
      @(negedge clk_i);
      int_fin_i = 1'b1;
      @(negedge clk_i);
      int_fin_i = 1'b0;
      checkOutput("fin_clear", 32'(irq_o), 32'd0);
      applyStimulus(1'b1, A_CTRL, 32'd0);
      checkOutput("stop_state", 32'(u_dut.state_q), 32'(ST_IDLE));

      $display("[TB] COUNT write versus tick");
      applyStimulus(1'b1, A_PRESCALE, 32'd0);
      applyStimulus(1'b1, A_LOAD, 32'h20);
      applyStimulus(1'b1, A_CTRL, 32'b001);
      applyStimulus(1'b1, A_COUNT, 32'h10);
      readCheck("cw_priority", A_COUNT, 32'h10);
      readCheck("cw_next", A_COUNT, 32'h11);
      applyStimulus(1'b1, A_CTRL, 32'd0);

      $display("[TB] LOAD zero expires every tick");
      applyStimulus(1'b1, A_COUNT, 32'd0);
      applyStimulus(1'b1, A_LOAD, 32'd0);
      applyStimulus(1'b1, A_PRESCALE, 32'd1);
      applyStimulus(1'b1, A_CTRL, 32'b111);
      @(negedge clk_i);
      checkOutput("l0_irq_pre", 32'(irq_o), 32'd0);
      @(negedge clk_i);
      checkOutput("l0_irq_at", 32'(irq_o), 32'd1);
      readCheck("l0_count", A_COUNT, 32'd0);

      $display("[TB] reset mid-run");
      applyStimulus(1'b1, A_PRESCALE, 32'd1000);
      applyStimulus(1'b1, A_COUNT, 32'd5);
      readCheck("mid_count", A_COUNT, 32'd5);
      checkOutput("mid_irq", 32'(irq_o), 32'd1);
      rst_n_i = 1'b0;
      #1;
      checkOutput("in_rst_irq", 32'(irq_o), 32'd0);
      checkOutput("in_rst_rdata", rdata_o, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checkOutput("post_irq", 32'(irq_o), 32'd0);
      checkOutput("post_state", 32'(u_dut.state_q), 32'(ST_IDLE));
      readCheck("post_ctrl", A_CTRL, 32'd0);
      readCheck("post_load", A_LOAD, 32'd0);
      readCheck("post_prescale", A_PRESCALE, 32'd0);
      readCheck("post_status", A_STATUS, 32'd0);
      repeat (5) @(negedge clk_i);
      readCheck("post_count", A_COUNT, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
